// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared constants, types and write-port priority helper for register_file_mp
package register_file_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int N_WR_MAX  = 4;

    typedef logic [XLEN_DEF-1:0]          xlen_t;
    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

    // Index of the highest write port flagged in hit; later ports override earlier ones.
    function automatic logic [1:0] wr_pick(input logic [N_WR_MAX-1:0] hit);
        logic [1:0] idx;
        idx = '0;
        for (int k = 0; k < N_WR_MAX; k++) begin
            if (hit[k]) idx = k[1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits, reservation handshake and read-port busy lookup
module rf_scoreboard
    import register_file_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    parameter  int N_RD  = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREGS-1:0] wr_clr,
    input  logic             alloc_valid,
    input  logic [AW-1:0]    alloc_addr,
    output logic             alloc_ready,
    input  logic [N_RD*AW-1:0] rd_addr,
    input  logic [N_RD-1:0]  rd_fwd,
    output logic [N_RD-1:0]  rd_busy
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] alloc_set;

    // Reservation accepted unless the destination is already reserved; r0 always accepts.
    always_comb begin
        alloc_ready = (alloc_addr == '0) || !busy[alloc_addr];
        alloc_set   = '0;
        if (alloc_valid && alloc_ready && (alloc_addr != '0)) begin
            alloc_set[alloc_addr] = 1'b1;
        end
    end

    // Writes release reservations; a fresh reservation granted in the same cycle wins,
    // since it belongs to a younger instruction than the write landing now.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~wr_clr) | alloc_set;
        end
    end

    // Busy as seen by each read port; a forwarded read already has its value.
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < N_RD; i++) begin
            rd_busy[i] = busy[rd_addr[i*AW +: AW]] && !rd_fwd[i];
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with busy scoreboard; REGFILE_BYPASS_EN enables write-to-read forwarding
module register_file_mp
    import register_file_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int N_RD  = 2,
    parameter  int N_WR  = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_RD*AW-1:0]   rd_addr,
    output logic [N_RD*XLEN-1:0] rd_data,
    output logic [N_RD-1:0]      rd_busy,
    input  logic [N_WR-1:0]      we,
    input  logic [N_WR*AW-1:0]   wr_addr,
    input  logic [N_WR*XLEN-1:0] wr_data,
    input  logic                 alloc_valid,
    input  logic [AW-1:0]        alloc_addr,
    output logic                 alloc_ready
);

    logic [XLEN-1:0]     regs    [NREGS];
    logic [N_WR_MAX-1:0] reg_hit [NREGS];
    logic [NREGS-1:0]    reg_wr;
    logic [N_RD-1:0]     rd_fwd;

    // Which write ports target each register this cycle; r0 is never written.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            reg_hit[r] = '0;
            for (int j = 0; j < N_WR; j++) begin
                reg_hit[r][j] = we[j] && (wr_addr[j*AW +: AW] == AW'(r));
            end
            reg_wr[r] = (r != 0) && (|reg_hit[r]);
        end
    end

    // Architectural state update; the highest-index port wins a same-address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (reg_wr[r]) begin
                    regs[r] <= wr_data[int'(wr_pick(reg_hit[r]))*XLEN +: XLEN];
                end
            end
        end
    end

    // Combinational read ports, optionally forwarding same-cycle write data.
    always_comb begin
        rd_data = '0;
        rd_fwd  = '0;
        for (int i = 0; i < N_RD; i++) begin
            if (rd_addr[i*AW +: AW] != '0) begin
                rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
            end
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < N_WR; j++) begin
                if (we[j] && (wr_addr[j*AW +: AW] != '0) &&
                    (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
                    rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                    rd_fwd[i]               = 1'b1;
                end
            end
`endif
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .N_RD  (N_RD)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .wr_clr      (reg_wr),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .alloc_ready (alloc_ready),
        .rd_addr     (rd_addr),
        .rd_fwd      (rd_fwd),
        .rd_busy     (rd_busy)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - directed and random self-checking bench for register_file_mp
module tb_register_file_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int N_RD  = 2;
    localparam int N_WR  = 2;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [N_RD*AW-1:0]   rd_addr;
    logic [N_RD*XLEN-1:0] rd_data;
    logic [N_RD-1:0]      rd_busy;
    logic [N_WR-1:0]      we;
    logic [N_WR*AW-1:0]   wr_addr;
    logic [N_WR*XLEN-1:0] wr_data;
    logic                 alloc_valid;
    logic [AW-1:0]        alloc_addr;
    logic                 alloc_ready;

    logic [63:0] m_reg  [NREGS];
    bit          m_busy [NREGS];
    int          vectors     = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    register_file_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .N_RD  (N_RD),
        .N_WR  (N_WR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .alloc_ready (alloc_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit fwd_hit(input int a, output logic [63:0] d);
        bit hit;
        hit = 1'b0;
        d   = '0;
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < N_WR; j++) begin
            if (we[j] && a != 0 && int'(wr_addr[j*AW +: AW]) == a) begin
                hit = 1'b1;
                d   = wr_data[j*XLEN +: XLEN];
            end
        end
`endif
        return hit;
    endfunction

    function automatic logic [63:0] exp_data(input int a);
        logic [63:0] d;
        if (a == 0) return '0;
        if (fwd_hit(a, d)) return d;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input int a);
        logic [63:0] d;
        if (a == 0) return 1'b0;
        if (fwd_hit(a, d)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic exp_ready();
        return (alloc_addr == '0) || !m_busy[alloc_addr];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NREGS; k++) begin
            m_reg[k]  = '0;
            m_busy[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit acc;
        int a;
        acc = alloc_valid && exp_ready();
        for (int j = 0; j < N_WR; j++) begin
            a = int'(wr_addr[j*AW +: AW]);
            if (we[j] && a != 0) begin
                m_reg[a]  = wr_data[j*XLEN +: XLEN];
                m_busy[a] = 1'b0;
            end
        end
        if (acc && alloc_addr != '0) m_busy[alloc_addr] = 1'b1;
    endtask

    task automatic check_all();
        for (int i = 0; i < N_RD; i++) begin
            check("rd_data", rd_data[i*XLEN +: XLEN], exp_data(int'(rd_addr[i*AW +: AW])));
            check("rd_busy", 64'(rd_busy[i]), 64'(exp_busy(int'(rd_addr[i*AW +: AW]))));
        end
        check("alloc_ready", 64'(alloc_ready), 64'(exp_ready()));
    endtask

    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        we          = '0;
        alloc_valid = 1'b0;
    endtask

    task automatic rd(input int i, input int a);
        rd_addr[i*AW +: AW] = AW'(a);
    endtask

    task automatic wr(input int j, input int a, input logic [63:0] d);
        we[j]                   = 1'b1;
        wr_addr[j*AW +: AW]     = AW'(a);
        wr_data[j*XLEN +: XLEN] = d;
    endtask

    task automatic alloc(input int a);
        alloc_valid = 1'b1;
        alloc_addr  = AW'(a);
    endtask

    initial begin
        rd_addr    = '0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_addr = '0;
        idle();
        model_reset();

        // reset state
        repeat (2) @(negedge clk);
        rd(0, 0); rd(1, 5);
        #1;
        check("rst_rd0", rd_data[0 +: 64], 64'h0);
        check("rst_rd5", rd_data[64 +: 64], 64'h0);
        rst = 1'b1;
        step();
        rd(0, 31);
        #1;
        check("rst_rd31", rd_data[0 +: 64], 64'h0);
        check("rst_busy31", 64'(rd_busy[0]), 64'h0);
        step();

        // write then read, same cycle and next cycle
        wr(0, 3, 64'h1234_5678_9ABC_DEF0);
        rd(0, 3);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("wr3_same", rd_data[0 +: 64], 64'h1234_5678_9ABC_DEF0);
`else
        check("wr3_same", rd_data[0 +: 64], 64'h0);
`endif
        step();
        idle();
        #1;
        check("wr3_next", rd_data[0 +: 64], 64'h1234_5678_9ABC_DEF0);
        step();

        // two ports to the same address
        wr(0, 9, 64'hAA);
        wr(1, 9, 64'hBB);
        step();
        idle();
        rd(0, 9);
        #1;
        check("wr9_prio", rd_data[0 +: 64], 64'hBB);
        step();

        // reserve 12, WAW stall, release by write
        alloc(12);
        rd(0, 12);
        #1;
        check("alloc12_rdy", 64'(alloc_ready), 64'h1);
        step();
        #1;
        check("alloc12_busy", 64'(rd_busy[0]), 64'h1);
        check("alloc12_stall", 64'(alloc_ready), 64'h0);
        step();
        wr(0, 12, 64'h55);
        #1;
        check("alloc12_wr_stall", 64'(alloc_ready), 64'h0);
        step();
        we = '0;
        #1;
        check("alloc12_reacc", 64'(alloc_ready), 64'h1);
        check("alloc12_data", rd_data[0 +: 64], 64'h55);
        check("alloc12_free", 64'(rd_busy[0]), 64'h0);
        step();
        idle();
        #1;
        check("alloc12_rebusy", 64'(rd_busy[0]), 64'h1);
        step();

        // register 0 ignores writes and reservations
        wr(0, 0, 64'hFFFF);
        alloc(0);
        rd(0, 0);
        #1;
        check("r0_rdy", 64'(alloc_ready), 64'h1);
        step();
        #1;
        check("r0_data", rd_data[0 +: 64], 64'h0);
        check("r0_busy", 64'(rd_busy[0]), 64'h0);
        step();
        idle();

        // allocation and write to a busy register in one cycle
        alloc(4);
        step();
        wr(0, 4, 64'h4444);
        rd(1, 4);
        #1;
        check("a4_stall", 64'(alloc_ready), 64'h0);
        step();
        we = '0;
        #1;
        check("a4_rdy", 64'(alloc_ready), 64'h1);
        check("a4_free", 64'(rd_busy[1]), 64'h0);
        step();
        idle();
        #1;
        check("a4_busy", 64'(rd_busy[1]), 64'h1);
        step();

        // mid-run reset clears data and reservations
        wr(0, 7, 64'hDEAD);
        step();
        idle();
        rd(0, 7);
        #1;
        check("r7_pre", rd_data[0 +: 64], 64'hDEAD);
        rst = 1'b0;
        model_reset();
        #1;
        check("r7_rst", rd_data[0 +: 64], 64'h0);
        check("r4_rst_busy", 64'(rd_busy[1]), 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            we          = N_WR'($urandom);
            wr_addr     = (N_WR*AW)'($urandom);
            wr_data     = {$urandom, $urandom, $urandom, $urandom};
            alloc_valid = 1'($urandom);
            alloc_addr  = AW'($urandom);
            rd_addr     = (N_RD*AW)'($urandom);
            if (n % 3 == 0) rd_addr[AW +: AW] = wr_addr[0 +: AW];
            if (n % 5 == 0) wr_addr[AW +: AW] = wr_addr[0 +: AW];
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port integer register file with a per-register busy scoreboard. Next-generation replacement for the fixed 32x64, 2-read/1-write file.
- Sits between decode/issue and writeback. Issue reserves a destination; writeback fills it and releases the reservation.
- Adds configurable width/depth/port counts, reset of architectural state, a multi-write priority rule and an optional write-to-read bypass.

Parameters:
- XLEN, 64, data width in bits.
- NREGS, 32, number of registers; power of two, >= 2. Register 0 is hardwired to zero.
- N_RD, 2, number of read ports.
- N_WR, 1, number of write ports (1..4).
- AW, $clog2(NREGS), address width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rd_addr  in  N_RD*AW  read addresses; port i uses slice [i*AW +: AW].
- rd_data  out  N_RD*XLEN  read data, combinational from rd_addr.
- rd_busy  out  N_RD  scoreboard busy bit of each read address.
- we  in  N_WR  write enables.
- wr_addr  in  N_WR*AW  write addresses.
- wr_data  in  N_WR*XLEN  write data.
- alloc_valid  in  1  issue requests reservation of alloc_addr.
- alloc_addr  in  AW  destination register to reserve.
- alloc_ready  out  1  reservation accepted this cycle.

Behaviour:
- Reset (rst=0, asynchronous): all registers 0 and all busy bits 0. rd_data reflects zeros immediately. alloc_ready=1 after release.
- A reset asserted mid-operation discards all pending writes and reservations; no partial state survives.
- Register 0 always reads 0 and is never busy. Writes and allocations to address 0 are accepted and ignored; alloc_ready=1 for address 0.
- Reads are combinational, zero latency, and return the register contents.
- Writes take effect at the posedge when we[j]=1. Write data is visible on reads the following cycle (without the optional feature).
- Multiple write ports targeting the same address in one cycle: the highest index j wins, for both data and busy clear.
- Scoreboard, per register: busy is set at posedge when alloc_valid && alloc_ready && alloc_addr!=0. Busy is cleared at posedge when any we[j]=1 to that address.
- alloc_ready = !busy[alloc_addr], or 1 when alloc_addr==0. This stalls WAW hazards.
- Allocation and a write to the same address in the same cycle: the write clears busy, then a new allocation is possible only in the next cycle, because alloc_ready is low while busy.
- A write to a non-busy register is legal: data is updated and busy stays 0.
- rd_busy[i] = busy[rd_addr[i]]. It is combinational and reflects registered state only; a same-cycle write does not clear it.
- No internal state machine beyond the registers and busy bits. Every transition is a single-cycle update.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: a read whose address matches an active write port (we[j]=1, address!=0) returns that port's wr_data in the same cycle, using the highest-index match. Its rd_busy is forced to 0.
- Undefined: pure register read, with one cycle from write to visibility.

Decomposition:
- Package register_file_pkg holds:
  - default constants XLEN_DEF=64 and NREGS_DEF=32;
  - typedef xlen_t (logic [XLEN_DEF-1:0]);
  - typedef reg_addr_t (logic [$clog2(NREGS_DEF)-1:0]);
  - the helper function for write-port priority select.
- One sub-module, rf_scoreboard, holds the busy vector, alloc_ready and rd_busy. The data array stays in the top module.

Test Plan:
- Reset, then read ports on addresses 0, 5 and 31 -> all return 0 and rd_busy=0. Assert rst low mid-run after writing r7=0xDEAD -> r7 reads 0 immediately.
- we[0]=1, wr_addr=3, wr_data=0x1234_5678_9ABC_DEF0; read addr 3 same cycle -> old value 0 (bypass off) or 0x1234_5678_9ABC_DEF0 (bypass on). Next cycle -> 0x1234_5678_9ABC_DEF0.
- N_WR=2, both ports write addr 9 with 0xAA (port 0) and 0xBB (port 1) -> r9=0xBB.
- alloc addr 12 -> alloc_ready=1, then rd_busy=1 on reads of 12. Second alloc of 12 -> alloc_ready=0. Write r12=0x55 -> busy clears next cycle and the alloc is accepted.
- Write 0xFFFF to addr 0 and alloc addr 0 -> r0 reads 0, alloc_ready=1, and rd_busy stays 0.
- Same cycle: alloc addr 4 (busy) and write addr 4 -> alloc_ready=0 that cycle, busy=0 after the edge, and alloc accepted the next cycle.
